// File: rtl/counter_sequencer.sv
// counter_sequencer: sequences LOAD/COUNT commands onto an external 4-bit counter and checks the result.
module counter_sequencer #(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [3:0] cmd_data,
    input  logic [3:0] cnt_q,
    output logic       cnt_enb,
    output logic       cnt_modo,
    output logic [3:0] cnt_data,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, LOAD, COUNT, CHECK} state_t;
    state_t     state;
    logic [3:0] step_q, exp_q, result_q;
    always_ff @(posedge clk)
        if (reset) begin
            state    <= IDLE;
            step_q   <= 4'd0;
            result_q <= 4'd0;
        end else
            case (state)
                IDLE:
                    if (cmd_valid && cmd_ready) begin
                        step_q <= cmd_data;
                        exp_q  <= cmd_op ? cnt_q + cmd_data : cmd_data;
                        state  <= !cmd_op ? LOAD : (cmd_data != 4'd0 ? COUNT : CHECK);
                    end
                LOAD: state <= CHECK;
                COUNT: begin
                    step_q <= step_q - 4'd1;
                    if (step_q == 4'd1) state <= CHECK;
                end
                CHECK: begin
                    result_q <= cnt_q;
                    state    <= IDLE;
                end
            endcase
    // Outputs are gated by reset so an abort takes effect in the very cycle reset rises.
    always_comb begin
        cmd_ready = !reset && state == IDLE;
        busy      = !reset && state != IDLE;
        cnt_enb   = !reset && (state == LOAD || state == COUNT);
        cnt_modo  = !reset && state == LOAD;
        cnt_data  = (!reset && state == LOAD) ? step_q : 4'd0;
        done      = !reset && state == CHECK;
        err       = done && CHECK_EN && cnt_q != exp_q;
        result    = done ? cnt_q : result_q;
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: scoreboard bench driving directed commands against a behavioural counter.
module tb_counter_sequencer;
    logic       clk = 0, reset = 1, cmd_valid = 0, cmd_op = 0, fault = 0;
    logic [3:0] cmd_data = 0, q_reg = 0, cnt_q;
    logic       cmd_ready, cnt_enb, cnt_modo, busy, done, err;
    logic [3:0] cnt_data, result;
    logic       cmd_ready_n, cnt_enb_n, cnt_modo_n, busy_n, done_n, err_n;
    logic [3:0] cnt_data_n, result_n;

    typedef struct {
        logic [3:0] res;
        logic       e;
        int         lat;
        int         np;
        logic [3:0] ld;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, pulses = 0;

    counter_sequencer #(.CHECK_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cnt_q(cnt_q), .cnt_enb(cnt_enb),
        .cnt_modo(cnt_modo), .cnt_data(cnt_data), .busy(busy), .done(done),
        .result(result), .err(err));

    counter_sequencer #(.CHECK_EN(1'b0)) dut_n (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_n),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cnt_q(cnt_q), .cnt_enb(cnt_enb_n),
        .cnt_modo(cnt_modo_n), .cnt_data(cnt_data_n), .busy(busy_n), .done(done_n),
        .result(result_n), .err(err_n));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (cnt_enb) q_reg <= cnt_modo ? cnt_data : q_reg + 4'd1;
    assign cnt_q = fault ? 4'd0 : q_reg;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks accepts and enable pulses, pops the scoreboard on every done.
    always @(negedge clk) begin
        exp_t e;
        if (cmd_valid && cmd_ready) begin
            acc_cyc = cyc;
            pulses  = 0;
        end
        if (cnt_enb) begin
            pulses++;
            if (cnt_modo && sb.size() > 0) chk("load_data", cnt_data, sb[0].ld);
        end
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("err", err, e.e);
                chk("latency", cyc - acc_cyc, e.lat);
                chk("pulses", pulses, e.np);
                chk("done_nocheck", done_n, 1);
                chk("err_nocheck", err_n, 0);
                chk("result_nocheck", result_n, e.res);
            end
        end
    end

    task automatic send(input logic op, input logic [3:0] d);
        logic ok = 0;
        cmd_valid = 1;
        cmd_op    = op;
        cmd_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
        cmd_valid = 0;
    endtask

    task automatic issue(input logic op, input logic [3:0] d, input logic [3:0] res,
                         input logic e, input int lat, input int np);
        sb.push_back('{res, e, lat, np, d});
        send(op, d);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cmd_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enb", cnt_enb, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        reset = 0;
        cmd_valid = 0;
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        @(posedge clk);
        #1;
        issue(0, 4'd9, 4'd9, 0, 2, 1);
        issue(0, 4'd5, 4'd5, 0, 2, 1);
        issue(1, 4'd3, 4'd8, 0, 4, 3);
        issue(0, 4'd14, 4'd14, 0, 2, 1);
        issue(1, 4'd3, 4'd1, 0, 4, 3);
        issue(1, 4'd0, 4'd1, 0, 1, 0);
        issue(0, 4'd0, 4'd0, 0, 2, 1);
        drain();
        fault = 1;
        issue(1, 4'd2, 4'd0, 1, 3, 2);
        drain();
        fault = 0;
        // Counter now holds 2; junk commands while busy must be ignored.
        issue(1, 4'd5, 4'd7, 0, 6, 5);
        cmd_valid = 1;
        begin
            logic seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                cmd_op   = i[0];
                cmd_data = 4'(i + 3);
                @(negedge clk);
                seen = done;
                if (!seen) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done expected done for COUNT 5");
            end
        end
        sb.push_back('{4'd3, 1'b0, 2, 1, 4'd3});
        cmd_op   = 0;
        cmd_data = 4'd3;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 0;
        drain();
        issue(0, 4'd0, 4'd0, 0, 2, 1);
        drain();
        send(1, 4'd10);
        repeat (3) @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_enb", cnt_enb, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_busy_after", busy, 0);
        chk("abort_pulses", pulses, 3);
        chk("abort_q_kept", q_reg, 3);
        repeat (15) @(posedge clk);
        #1;
        issue(1, 4'd1, 4'd4, 0, 2, 1);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
